color_bounce_sequencer: RTL and testbench

Top-level game sequencer for Color Bounce. Divides the system clock into frame ticks. Each frame it runs one erase → update → latch → draw pass:
- drives the ball/platform updater through statesig;
- handshakes with the VGA erase and draw plotters;
- tells the game-state registers when to load the updater's results.
It also handles game start, game over, and frame-overrun and plotter-timeout errors.

---
 rtl/color_bounce_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_color_bounce_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/color_bounce_sequencer.sv
// Color Bounce frame sequencer. It divides clk into frame ticks. Each frame it
// runs one erase -> update -> latch -> draw pass, handshaking with the
// plotters and the updater. It also handles start/game-over and sticky errors.
module color_bounce_sequencer #(
   parameter int FRAME_DIV = 833334,
   parameter int TIMEOUT   = 65535,
   parameter int OVER_HOLD = 120
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        upd_gameover,
   input  logic        erase_done,
   input  logic        draw_done,
   output logic [1:0]  statesig,
   output logic        init_go,
   output logic        erase_go,
   output logic        draw_go,
   output logic        load_regs,
   output logic        playing,
   output logic        game_over,
   output logic        overrun,
   output logic        timeout_err,
   output logic [15:0] frames
);

   localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int WD_W   = $clog2(TIMEOUT + 1);
   localparam int HOLD_W = $clog2(OVER_HOLD + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FRAME_DIV - 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVER_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_WAIT, S_ERASE, S_UPDATE, S_LATCH, S_DRAW, S_OVER
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [15:0]        frames_q, frames_d;
   logic               pend_q, pend_d;
   logic               overrun_q, overrun_d;
   logic               tmo_q, tmo_d;
   logic               start_q, start_d;
   // start_arm_q masks the first sampled cycle after reset. A start that is
   // already held high at reset release is then not seen as an edge.
   logic               start_arm_q, start_arm_d;
   logic               tick;
   logic               start_edge;

   // State and counter registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         wd_q        <= '0;
         hold_q      <= '0;
         frames_q    <= '0;
         pend_q      <= 1'b0;
         overrun_q   <= 1'b0;
         tmo_q       <= 1'b0;
         start_q     <= 1'b0;
         start_arm_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         wd_q        <= wd_d;
         hold_q      <= hold_d;
         frames_q    <= frames_d;
         pend_q      <= pend_d;
         overrun_q   <= overrun_d;
         tmo_q       <= tmo_d;
         start_q     <= start_d;
         start_arm_q <= start_arm_d;
      end
   end

   // Next-state logic: frame divider, FSM transitions, counters and decoded outputs.
   always_comb begin
      tick        = (div_q == DIV_LAST);
      div_d       = tick ? '0 : div_q + DIV_W'(1);
      start_d     = start;
      start_arm_d = 1'b1;
      start_edge  = start & ~start_q & start_arm_q;

      state_d     = state_q;
      wd_d        = '0;
      hold_d      = hold_q;
      frames_d    = frames_q;
      pend_d      = pend_q;
      overrun_d   = overrun_q;
      tmo_d       = tmo_q;

      statesig    = 2'b00;
      init_go     = 1'b0;
      erase_go    = 1'b0;
      draw_go     = 1'b0;
      load_regs   = 1'b0;
      playing     = 1'b0;
      game_over   = 1'b0;

      // A second tick before the first was consumed means the pass overran.
      if (tick && pend_q && (state_q != S_IDLE)) overrun_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start_edge) state_d = S_INIT;
         end
         S_INIT: begin
            init_go   = 1'b1;
            playing   = 1'b1;
            frames_d  = '0;
            overrun_d = 1'b0;
            tmo_d     = 1'b0;
            pend_d    = 1'b0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            playing = 1'b1;
            if (pend_q) begin
               pend_d  = 1'b0;
               state_d = S_ERASE;
            end
         end
         S_ERASE: begin
            statesig = 2'b01;
            playing  = 1'b1;
            erase_go = (wd_q == '0);
            if (erase_done) begin
               state_d = S_UPDATE;
            end else if (wd_q == WD_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_UPDATE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_UPDATE: begin
            statesig = 2'b10;
            playing  = 1'b1;
            state_d  = S_LATCH;
         end
         S_LATCH: begin
            load_regs = 1'b1;
            playing   = 1'b1;
            if (upd_gameover) begin
               hold_d  = '0;
               state_d = S_OVER;
            end else begin
               state_d = S_DRAW;
            end
         end
         S_DRAW: begin
            statesig = 2'b11;
            playing  = 1'b1;
            draw_go  = (wd_q == '0);
            if (draw_done || (wd_q == WD_LAST)) begin
               if (!draw_done) tmo_d = 1'b1;
               if (frames_q != 16'hFFFF) frames_d = frames_q + 16'd1;
               state_d = S_WAIT;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_OVER: begin
            game_over = 1'b1;
            if (start_edge) begin
               state_d = S_INIT;
            end else if (tick) begin
               hold_d = hold_q + HOLD_W'(1);
               if (hold_q == HOLD_LAST) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A tick always lands in tick_pending, even on a cycle that clears it.
      if (tick) pend_d = 1'b1;
   end

   assign overrun     = overrun_q;
   assign timeout_err = tmo_q;
   assign frames      = frames_q;

endmodule

// File: tb/tb_color_bounce_sequencer.sv
// Bench for color_bounce_sequencer. A cycle-level reference model tracks the
// game phase by name, with the frame tick derived from the cycle count. Every
// DUT output is compared against the model at each falling edge.
module tb_color_bounce_sequencer;

   localparam int FD = 8;
   localparam int TO = 16;
   localparam int OH = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        start, upd_gameover, erase_done, draw_done;
   logic [1:0]  statesig;
   logic        init_go, erase_go, draw_go, load_regs, playing, game_over, overrun, timeout_err;
   logic [15:0] frames;

   int pass_cnt = 0;
   int total_cnt = 0;

   color_bounce_sequencer #(.FRAME_DIV(FD), .TIMEOUT(TO), .OVER_HOLD(OH)) dut (
      .clk(clk), .resetn(resetn), .start(start), .upd_gameover(upd_gameover),
      .erase_done(erase_done), .draw_done(draw_done), .statesig(statesig),
      .init_go(init_go), .erase_go(erase_go), .draw_go(draw_go), .load_regs(load_regs),
      .playing(playing), .game_over(game_over), .overrun(overrun),
      .timeout_err(timeout_err), .frames(frames)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   string ph, nx;
   int    cyc, enter, hold, frm, dwell;
   bit    pend, ovr, tmo, prev, m_tick, st_edge;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ph = "idle"; cyc = 0; enter = 0; hold = 0; frm = 0;
         pend = 0; ovr = 0; tmo = 0; prev = 0;
      end else begin
         m_tick  = (cyc % FD) == FD - 1;
         st_edge = (cyc > 0) && start && !prev;
         dwell   = cyc - enter;
         nx      = ph;
         if (m_tick && pend && ph != "idle") ovr = 1;
         if (ph == "idle") begin
            if (st_edge) nx = "init";
         end else if (ph == "init") begin
            frm = 0; ovr = 0; tmo = 0; pend = 0; nx = "wait";
         end else if (ph == "wait") begin
            if (pend) begin pend = 0; nx = "erase"; enter = cyc + 1; end
         end else if (ph == "erase") begin
            if (erase_done || dwell == TO - 1) begin
               if (!erase_done) tmo = 1;
               nx = "update";
            end
         end else if (ph == "update") begin
            nx = "latch";
         end else if (ph == "latch") begin
            if (upd_gameover) begin nx = "over"; hold = 0; end
            else begin nx = "draw"; enter = cyc + 1; end
         end else if (ph == "draw") begin
            if (draw_done || dwell == TO - 1) begin
               if (!draw_done) tmo = 1;
               if (frm < 65535) frm++;
               nx = "wait";
            end
         end else if (ph == "over") begin
            if (st_edge) nx = "init";
            else if (m_tick) begin
               hold++;
               if (hold == OH) nx = "idle";
            end
         end
         if (m_tick) pend = 1;
         ph   = nx;
         cyc++;
         prev = start;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      assert (act === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
   endtask

   task automatic check_all();
      logic [31:0] e_ss;
      e_ss = (ph == "erase") ? 1 : (ph == "update") ? 2 : (ph == "draw") ? 3 : 0;
      chk("statesig",  statesig,  e_ss);
      chk("init_go",   init_go,   32'(ph == "init"));
      chk("erase_go",  erase_go,  32'(ph == "erase" && cyc == enter));
      chk("draw_go",   draw_go,   32'(ph == "draw" && cyc == enter));
      chk("load_regs", load_regs, 32'(ph == "latch"));
      chk("playing",   playing,   32'(ph != "idle" && ph != "over"));
      chk("game_over", game_over, 32'(ph == "over"));
      chk("overrun",   overrun,   32'(ovr));
      chk("timeout",   timeout_err, 32'(tmo));
      chk("frames",    frames,    32'(frm));
      chk("one_hot",   32'($countones({init_go, erase_go, draw_go, load_regs}) <= 1), 32'd1);
   endtask

   // ---------------- stimulus helpers ----------------
   int e_dly, d_dly, e_cnt, d_cnt, go_pct;
   bit stray, rand_start;

   task automatic drive_inputs();
      erase_done = 1'b0;
      draw_done  = 1'b0;
      if (erase_go) e_cnt = (e_dly == -2) ? int'($urandom_range(0, 12)) : e_dly;
      if (draw_go)  d_cnt = (d_dly == -2) ? int'($urandom_range(0, 12)) : d_dly;
      if (e_cnt == 0) erase_done = 1'b1;
      if (d_cnt == 0) draw_done  = 1'b1;
      if (e_cnt >= 0) e_cnt--;
      if (d_cnt >= 0) d_cnt--;
      if (stray && $urandom_range(0, 15) == 0) erase_done = 1'b1;
      if (stray && $urandom_range(0, 15) == 0) draw_done  = 1'b1;
      upd_gameover = ($urandom_range(0, 99) < go_pct);
      if (rand_start) start = ($urandom_range(0, 5) == 0);
   endtask

   task automatic cyc_step(input int n);
      repeat (n) begin
         @(negedge clk);
         check_all();
         drive_inputs();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      start = 1'b1; upd_gameover = 1'b0; erase_done = 1'b0; draw_done = 1'b0;
      e_dly = 3; d_dly = 5; e_cnt = -1; d_cnt = -1; go_pct = 0; stray = 0; rand_start = 0;

      // Reset with start held high; releasing reset must not count as an edge.
      #2 resetn = 1'b0;
      #1 check_all();
      cyc_step(1);
      resetn = 1'b1;
      cyc_step(4);
      chk("held_start_idle", playing, 32'd0);

      // Start edge -> init_go in the following cycle.
      start = 1'b0;
      cyc_step(2);
      start = 1'b1;
      cyc_step(1);
      chk("init_after_edge", init_go, 32'd1);
      start = 1'b0;

      // Normal frames: erase done after 3 cycles, draw done after 5.
      cyc_step(60);

      // Stray start while playing is ignored; then withhold draw_done for timeouts.
      start = 1'b1; cyc_step(1); start = 1'b0;
      d_dly = -1;
      cyc_step(80);

      // Restart clears errors; long draw causes overrun.
      start = 1'b1; cyc_step(1); start = 1'b0;
      d_dly = 12;
      cyc_step(80);

      // Randomized plotter latencies with stray done pulses.
      e_dly = -2; d_dly = -2; stray = 1;
      cyc_step(400);

      // Game over, run out the hold back to idle.
      go_pct = 100; stray = 0;
      cyc_step(60);

      // Restart and press start during the game-over display.
      start = 1'b1; cyc_step(1); start = 1'b0;
      n = 0;
      while (game_over !== 1'b1 && n < 200) begin cyc_step(1); n++; end
      chk("reach_over", game_over, 32'd1);
      cyc_step(2);
      start = 1'b1; cyc_step(1); start = 1'b0;
      cyc_step(3);

      // Fully random phase including random start activity.
      go_pct = 20; rand_start = 1; stray = 1;
      cyc_step(300);

      // Reset in the middle of a draw.
      rand_start = 0; stray = 0; go_pct = 0; e_dly = 2; d_dly = 8;
      start = 1'b0; cyc_step(2);
      start = 1'b1; cyc_step(1); start = 1'b0;
      n = 0;
      while (statesig !== 2'b11 && n < 200) begin cyc_step(1); n++; end
      chk("reach_draw", statesig, 32'd3);
      #2 resetn = 1'b0;
      #1;
      chk("rst_statesig", statesig, 32'd0);
      chk("rst_playing",  playing,  32'd0);
      chk("rst_draw_go",  draw_go,  32'd0);
      chk("rst_frames",   frames,   32'd0);
      check_all();
      @(negedge clk);
      resetn = 1'b1;
      cyc_step(12);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
